// File: rtl/wb_regfile.sv
// wb_regfile: writeback source select, 32-entry register file with write-through read bypass, retired-write counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_alu_res,
  input  logic [DATA_W-1:0] wb_pc_plus8,
  input  logic [1:0]        wb_data_src,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_commit,
  output logic [CNT_W-1:0]  retire_cnt
);
  logic [DATA_W-1:0] regs_q [2**ADDR_W];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  always_comb begin
    wb_data   = wb_data_src == 2'b01 ? wb_mem_data : wb_data_src == 2'b10 ? wb_pc_plus8 : wb_alu_res;
    wb_commit = rst & wb_we & (wb_addr != '0);
    cnt_d     = cnt_q + CNT_W'(1);
    // reads show the cleared state while reset is held
    rd_data1  = (!rst || rd_addr1 == '0) ? '0 : (wb_commit && rd_addr1 == wb_addr) ? wb_data : regs_q[rd_addr1];
    rd_data2  = (!rst || rd_addr2 == '0) ? '0 : (wb_commit && rd_addr2 == wb_addr) ? wb_data : regs_q[rd_addr2];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else if (wb_commit) begin
      regs_q[wb_addr] <= wb_data;
      cnt_q           <= cnt_d;
    end
  end
  assign retire_cnt = cnt_q;
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register. It selects the writeback value from the registered memory data, ALU result or PC+8, and commits it to the 32-entry general-purpose register file. It serves the ID-stage read ports with same-cycle write-through bypass and keeps a retired-write counter for performance monitoring.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register index width (2**ADDR_W entries)
CNT_W, 32, width of the retired-write counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low
wb_mem_data  input  DATA_W  load data from MEM/WB register
wb_alu_res  input  DATA_W  ALU result from MEM/WB register
wb_pc_plus8  input  DATA_W  link address from MEM/WB register
wb_data_src  input  2  writeback select: 00 ALU, 01 memory, 10 PC+8, 11 reserved
wb_addr  input  ADDR_W  destination register index
wb_we  input  1  register write enable
rd_addr1  input  ADDR_W  read port 1 index (ID stage)
rd_addr2  input  ADDR_W  read port 2 index (ID stage)
rd_data1  output  DATA_W  read port 1 data, combinational
rd_data2  output  DATA_W  read port 2 data, combinational
wb_data  output  DATA_W  selected writeback value, combinational (forwarding source for EX)
wb_commit  output  1  high when the current cycle performs a real register write
retire_cnt  output  CNT_W  count of committed register writes since reset

Behaviour:
- Reset is decided: rst is synchronous and active-low; clk is the clock.
- On a rising edge with rst=0, all 32 entries clear to 0 and retire_cnt clears to 0. Combinational outputs follow the cleared state in the same cycle. wb_commit is forced to 0 while rst=0.
- Write data mux: 00 selects wb_alu_res, 01 selects wb_mem_data, 10 selects wb_pc_plus8. 11 (reserved) selects wb_alu_res. No width conversion is applied; every source is DATA_W.
- wb_commit = rst & wb_we & (wb_addr != 0).
- Write: on a rising edge with wb_commit=1, entry[wb_addr] <= wb_data. Entry 0 is never written and always reads 0.
- Read, per port independently:
  - If rd_addr==0, the output is 0.
  - Otherwise, if wb_commit=1 and rd_addr==wb_addr, the output is wb_data (write-through bypass, zero-cycle latency).
  - Otherwise, the output is entry[rd_addr].
- Both read ports may address the same register or the write target at the same time; each port resolves independently.
- retire_cnt increments by 1 on each edge with wb_commit=1 and wraps modulo 2**CNT_W with no saturation. Writes with wb_we=1 and wb_addr=0 are not counted.
- Write latency: a value written at edge N is visible from the array in the cycle after N. It is visible through the bypass during the cycle that precedes edge N.
- Reset asserted mid-stream: the pending write in that cycle is discarded. wb_commit=0, so the bypass is also suppressed.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release. Read any rd_addr1/rd_addr2 -> 0, retire_cnt=0, wb_commit=0.
- Source select: wb_we=1, wb_addr=5, alu=0x11, mem=0x22, pc8=0x33. Drive src 00/01/10/11 on consecutive cycles -> reg5 reads 0x11, 0x22, 0x33, 0x11 respectively; retire_cnt=4.
- Zero register: wb_we=1, wb_addr=0, alu=0xDEADBEEF. rd_addr1=0 -> rd_data1=0 in the same and next cycle; wb_commit=0; retire_cnt unchanged.
- Bypass: reg7=0xAAAA. In one cycle drive wb_we=1, wb_addr=7, alu=0x5555, rd_addr1=rd_addr2=7 -> both ports read 0x5555 in that cycle and from the array afterwards. With wb_we=0 and the same inputs -> both read 0xAAAA.
- Mid-stream reset: write reg3=0x1234 and commit it. Next cycle drive rst=0 with wb_we=1, wb_addr=4 -> after release reg3=0, reg4=0, retire_cnt=0.
- Counter wrap: with CNT_W=4, perform 17 committed writes -> retire_cnt=1.
